// File: rtl/conv_pkg.sv
// Shared conv-layer definitions: default sample width, pooling FSM states, clog2 helper.
package conv_pkg;

   localparam int CONV_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SCAN     = 3'd1,
      DRAIN    = 3'd2,
      DONE     = 3'd3,
      WAIT_LOW = 3'd4
   } pool_state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/maxpool_engine_if.sv
// Pool engine bus: start/base from the layer controller, conv buffer read port, pool buffer write port.
interface maxpool_engine_if #(
   parameter int DATA_W     = conv_pkg::CONV_DATA_W,
   parameter int IN_ADDR_W  = 10,
   parameter int OUT_ADDR_W = 12
);
   logic                  pool_en;
   logic [OUT_ADDR_W-1:0] out_base;
   logic                  rd_en;
   logic [IN_ADDR_W-1:0]  rd_addr;
   logic [DATA_W-1:0]     rd_data;
   logic                  wr_en;
   logic [OUT_ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic                  busy;
   logic                  pool_done;

   modport master (
      output pool_en, out_base, rd_data,
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, pool_done
   );

   modport slave (
      input  pool_en, out_base, rd_data,
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, pool_done
   );
endinterface

// File: rtl/pool_window_ctr.sv
// Tap/column/row counters for a 2x2 stride-2 window scan; row and column bases are kept
// incrementally so the read address needs no multiplier.
module pool_window_ctr
   import conv_pkg::*;
#(
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28,
   parameter int IN_ADDR_W = 10
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clr,
   input  logic                 i_adv,
   output logic [IN_ADDR_W-1:0] o_addr,
   output logic [1:0]           o_t,
   output logic                 o_last_tap
);
   localparam int POOL_W = IMG_W / 2;
   localparam int POOL_H = IMG_H / 2;
   localparam int PC_W   = clog2(POOL_W + 1);
   localparam int PR_W   = clog2(POOL_H + 1);

   localparam logic [PC_W-1:0]      LP_PC_LAST = PC_W'(POOL_W - 1);
   localparam logic [PR_W-1:0]      LP_PR_LAST = PR_W'(POOL_H - 1);
   localparam logic [IN_ADDR_W-1:0] LP_ROW1    = IN_ADDR_W'(IMG_W);
   localparam logic [IN_ADDR_W-1:0] LP_ROW2    = IN_ADDR_W'(2 * IMG_W);

   logic [1:0]           r_t;
   logic [PC_W-1:0]      r_pc;
   logic [PR_W-1:0]      r_pr;
   logic [IN_ADDR_W-1:0] r_col;
   logic [IN_ADDR_W-1:0] r_row;
   logic                 w_last_col;
   logic                 w_last_row;

   assign w_last_col = (r_pc == LP_PC_LAST);
   assign w_last_row = (r_pr == LP_PR_LAST);

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_t   <= '0;
         r_pc  <= '0;
         r_pr  <= '0;
         r_col <= '0;
         r_row <= '0;
      end else if (i_adv) begin
         r_t <= r_t + 2'd1;
         if (r_t == 2'd3) begin
            if (w_last_col) begin
               r_pc  <= '0;
               r_col <= '0;
               if (w_last_row) begin
                  r_pr  <= '0;
                  r_row <= '0;
               end else begin
                  r_pr  <= r_pr + PR_W'(1);
                  r_row <= r_row + LP_ROW2;
               end
            end else begin
               r_pc  <= r_pc + PC_W'(1);
               r_col <= r_col + IN_ADDR_W'(2);
            end
         end
      end
   end

   // r_row = 2*pr*IMG_W, r_col = 2*pc; t[1] selects the lower row, t[0] the right column
   assign o_addr     = r_row + (r_t[1] ? LP_ROW1 : '0) + r_col
                       + {{(IN_ADDR_W-1){1'b0}}, r_t[0]};
   assign o_t        = r_t;
   assign o_last_tap = (r_t == 2'd3) && w_last_col && w_last_row;

endmodule

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 signed max-pool engine: scans one conv channel, writes the pooled map,
// pulses pool_done once per pool_en high period.
module maxpool_engine
   import conv_pkg::*;
#(
   parameter int DATA_W     = CONV_DATA_W,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int IN_ADDR_W  = 10,
   parameter int OUT_ADDR_W = 12,
   parameter int RELU       = 0
)(
   input logic             clk,
   input logic             rst,
   maxpool_engine_if.slave bus
);
   pool_state_t                 r_state;
   logic                        r_rd_en;
   logic [IN_ADDR_W-1:0]        r_rd_addr;
   logic [1:0]                  r_rd_t;
   logic                        r_vld;
   logic [1:0]                  r_vld_t;
   logic signed [DATA_W-1:0]    r_acc;
   logic                        r_wr_en;
   logic [OUT_ADDR_W-1:0]       r_wr_addr;
   logic [OUT_ADDR_W-1:0]       r_base;
   logic [OUT_ADDR_W-1:0]       r_widx;
   logic                        r_busy;
   logic                        r_done;

   logic                        w_clr;
   logic                        w_adv;
   logic [IN_ADDR_W-1:0]        w_addr;
   logic [1:0]                  w_t;
   logic                        w_last_tap;
   logic signed [DATA_W-1:0]    w_rd;
   logic signed [DATA_W-1:0]    w_max;
   logic signed [DATA_W-1:0]    w_pool;

   assign w_clr = (r_state == IDLE);
   assign w_adv = (r_state == SCAN) && bus.pool_en;

   pool_window_ctr #(
      .IMG_W     (IMG_W),
      .IMG_H     (IMG_H),
      .IN_ADDR_W (IN_ADDR_W)
   ) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_clr),
      .i_adv      (w_adv),
      .o_addr     (w_addr),
      .o_t        (w_t),
      .o_last_tap (w_last_tap)
   );

   // The last tap of a window is compared on the fly so the write lands in the cycle its data arrives
   assign w_rd    = bus.rd_data;
   assign w_max   = ((r_vld_t == 2'd0) || (w_rd > r_acc)) ? w_rd : r_acc;
   assign w_pool  = ((RELU != 0) && w_max[DATA_W-1]) ? '0 : w_max;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_rd_t    <= '0;
         r_vld     <= 1'b0;
         r_vld_t   <= '0;
         r_acc     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_base    <= '0;
         r_widx    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_vld   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.pool_en) begin
                  r_state <= SCAN;
                  r_base  <= bus.out_base;
                  r_widx  <= '0;
               end
            end
            SCAN, DRAIN: begin
               if (!bus.pool_en) begin
                  r_state <= IDLE;
               end else begin
                  r_busy  <= 1'b1;
                  r_vld   <= r_rd_en;
                  r_vld_t <= r_rd_t;
                  if (r_vld) begin
                     r_acc <= w_max;
                  end
                  if (r_rd_en && (r_rd_t == 2'd3)) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_base + r_widx;
                     r_widx    <= r_widx + OUT_ADDR_W'(1);
                  end
                  if (r_state == SCAN) begin
                     r_rd_en   <= 1'b1;
                     r_rd_addr <= w_addr;
                     r_rd_t    <= w_t;
                     if (w_last_tap) begin
                        r_state <= DRAIN;
                     end
                  end else begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_busy  <= 1'b1;
               r_done  <= 1'b1;
               r_state <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!bus.pool_en) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.rd_en     = r_rd_en;
   assign bus.rd_addr   = r_rd_addr;
   assign bus.wr_en     = r_wr_en;
   assign bus.wr_addr   = r_wr_addr;
   assign bus.wr_data   = r_wr_en ? w_pool : '0;
   assign bus.busy      = r_busy;
   assign bus.pool_done = r_done;

endmodule

// File: doc/maxpool_engine.md
# maxpool_engine

2x2 stride-2 max-pooling engine downstream of the convolution stage in the conv layer. It is started by the top-level layer controller's `pool` enable and reads one output channel of the convolution result buffer. It writes the pooled map into the pool output buffer and returns a one-cycle `pool_done` pulse to the controller, which then advances to the next output channel.

## Interface
- `DATA_W`, 16: signed sample width, two's complement.
- `IMG_W`, 28: conv feature-map width in samples, ≥2.
- `IMG_H`, 28: conv feature-map height in samples, ≥2.
- `IN_ADDR_W`, 10: conv buffer address width, ≥ clog2(IMG_W*IMG_H).
- `OUT_ADDR_W`, 12: pool buffer address width.
- `RELU`, 0: 1 clamps each pooled result to ≥0.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pool_en`  in  1  level start/enable from the layer controller.
- `out_base`  in  OUT_ADDR_W  pool buffer base address for this channel; sampled at start.
- `rd_en`  out  1  conv buffer read strobe.
- `rd_addr`  out  IN_ADDR_W  conv buffer read address.
- `rd_data`  in  DATA_W  read data, valid exactly 1 cycle after `rd_en`.
- `wr_en`  out  1  pool buffer write strobe.
- `wr_addr`  out  OUT_ADDR_W  pool buffer write address.
- `wr_data`  out  DATA_W  pooled value.
- `busy`  out  1  high from start until the done cycle.
- `pool_done`  out  1  one-cycle completion pulse.

## Operation
- POOL_W = IMG_W/2 and POOL_H = IMG_H/2, both floor. N = POOL_W*POOL_H windows.
- With odd dimensions, the last column or row is never read.
- Windows are scanned in raster order: `pc` is the fast index, `pr` the slow index.
- Taps within a window are issued in order t=0..3: (0,0), (0,1), (1,0), (1,1).
- `rd_addr` = (2*pr+dy)*IMG_W + 2*pc + dx.
- Running max is signed:
  - tap 0 loads the accumulator;
  - taps 1–3 replace it when `rd_data` > acc.
- `wr_data` = final max, or max(final max, 0) when RELU=1.
- `wr_addr` = latched `out_base` + window index. Addition wraps modulo 2^OUT_ADDR_W.
- FSM states:
  - IDLE: on `pool_en`=1, go to SCAN and latch `out_base`.
  - SCAN: issue one read per cycle for all 4N taps, then go to DRAIN.
  - DRAIN: absorb the final tap, write, go to DONE.
  - DONE: pulse `pool_done`, go to WAIT_LOW.
  - WAIT_LOW: stay until `pool_en`=0, then go to IDLE.
- Abort: `pool_en`=0 in SCAN or DRAIN sends the FSM to IDLE on the next edge.
  - From that cycle onward: `rd_en`=`wr_en`=0, no `pool_done`.
  - The in-flight read is discarded.
- `rst` has priority in every state. It forces IDLE and clears all counters and the accumulator.
- Reset values: `rd_en`, `wr_en`, `busy`, `pool_done` = 0; `rd_addr`, `wr_addr`, `wr_data` = 0.

## Timing
- Cycle 0 = the edge at which `pool_en`=1 is sampled in IDLE.
- Window w, tap t: `rd_en` high in cycle 1+4w+t.
- Matching `rd_data` arrives in cycle 2+4w+t.
- `wr_en` for window w is high in cycle 4w+5, registered, for one cycle.
- Throughput is one window per 4 cycles; the write of window w overlaps the reads of window w+1.
- `pool_done` is high in cycle 4N+2, one cycle after the last write. `busy` is high in cycles 1..4N+2.
- Total latency from start to done is 4N+2 cycles. For a 28x28 map (N=196), this is 786.
- `pool_done` is never asserted twice for one `pool_en` high period.

## Structure
- Shared package `conv_pkg` holds:
  - `DATA_W` default;
  - FSM state encodings IDLE/SCAN/DRAIN/DONE/WAIT_LOW, 3 bits;
  - a clog2 helper function.
- Sub-module `pool_window_ctr` holds the tap/column/row counters.
  - It produces `rd_addr` and `t`.
  - It flags `last_tap`, asserted at t=3 of window N-1.
- Top level holds the FSM, the one-cycle read-valid delay, the accumulator, the ReLU, and the write registers.

## Test plan
- 4x4 map holding 0..15, `out_base`=0x40.
  - Writes 5, 7, 13, 15 to 0x40..0x43 in cycles 5, 9, 13, 17.
  - `pool_done` in cycle 18.
- Single window {-3, -7, -1, -9}:
  - RELU=0 writes -1.
  - RELU=1 writes 0.
  - Tie case {4, 4, 4, 4} writes 4.
- 5x5 map:
  - Exactly 4 writes.
  - `rd_addr` never takes 4, 9, 14, 19, or 20..24.
  - `pool_done` in cycle 18.
- Abort: drop `pool_en` in cycle 6 of a 4x4 run.
  - No `rd_en` or `wr_en` from cycle 7; `pool_done` never asserted; `busy`=0 from cycle 7.
  - A fresh start afterwards reproduces the first scenario.
- `rst` in cycle 10 of a 4x4 run.
  - All outputs 0 next cycle; FSM in IDLE.
  - A restart begins cleanly, with `wr_addr` starting at the new `out_base`.
- `pool_en` held high 20 cycles past `pool_done`.
  - No second scan.
  - After one low cycle and re-assertion, the scan restarts at `rd_addr`=0.
